// File: rtl/request_encoder_pkg.sv
// rtl/request_encoder_pkg.sv - shared encoder/decoder constants: request count and FSM encodings
package request_encoder_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // One-hot mask for a request index.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] mask;
    mask = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first set bit at or after ptr, wrapping
module rr_priority_pick
  import request_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] eff,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   index
);

  // Walk offsets from farthest to nearest so the nearest set bit overwrites and wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    any   = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (eff[cand]) begin
        any   = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/request_encoder.sv
// rtl/request_encoder.sv - round-robin 4:2 request encoder with pending queue and valid/ready handshake
module request_encoder
  import request_encoder_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic ready,
  output logic address0,
  output logic address1,
  output logic valid,
  output logic overflow
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic               overflow_q, overflow_d;

  logic [NUM_REQ-1:0] new_req;
  logic [NUM_REQ-1:0] eff;
  logic [NUM_REQ-1:0] sel_oh;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               sel_en;
  logic               do_sel;

  assign new_req = {req3, req2, req1, req0} & {NUM_REQ{enable}};
  assign eff     = pending_q | new_req;

  // A new address may be taken when nothing is presented or the current one is being accepted.
  assign sel_en  = (state_q == ST_IDLE) || ready;
  assign do_sel  = sel_en && pick_any;
  assign sel_oh  = do_sel ? idx_to_onehot(pick_idx) : '0;

  rr_priority_pick u_pick (
    .eff   (eff),
    .ptr   (ptr_q),
    .any   (pick_any),
    .index (pick_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter/stay PRESENT whenever a selection happens, leave only on accept with nothing left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_any) state_d = ST_PRESENT;
      ST_PRESENT: if (ready && !pick_any) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode: valid mirrors the PRESENT state flop.
  always_comb begin
    valid = 1'b0;
    if (state_q == ST_PRESENT) valid = 1'b1;
  end

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign overflow = overflow_q;

  // Datapath next values: selected lines keep only a fresh request queued, others accumulate; a repeat on a pending unselected line is lost.
  always_comb begin
    pending_d  = (pending_q & ~sel_oh) | (new_req & ~sel_oh) | (pending_q & new_req & sel_oh);
    overflow_d = overflow_q | (|(pending_q & new_req & ~sel_oh));
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    if (do_sel) begin
      addr_d = pick_idx;
      ptr_d  = pick_idx + IDX_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
